// File: rtl/lc3b_pkg.sv
// Shared types and constants for the LC-3b memory responder.
// The FSM state encoding, the R_W / DATA_SIZE bus encodings and the
// default access latency live here so the datapath side and the memory
// model agree on them.
package lc3b_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } memState_t;

   localparam logic RW_READ   = 1'b0;
   localparam logic RW_WRITE  = 1'b1;

   localparam logic SIZE_BYTE = 1'b0;
   localparam logic SIZE_WORD = 1'b1;

   localparam int DEFAULT_LATENCY = 5;

endpackage

// File: rtl/lc3b_mem_array.sv
// Byte-lane-writable 16-bit word array behind the LC-3b memory responder.
// One shared word address; the read port is combinational so the FSM can
// capture the addressed word on the same edge it raises R. Each byte
// lane has its own write enable so byte stores leave the other half alone.
module lc3b_mem_array #(
   parameter int    WORD_BITS = 15,
   parameter string INIT_FILE = ""
) (
   input  logic                 clk,
   input  logic [WORD_BITS-1:0] i_wordAddr,
   input  logic [1:0]           i_byteEn,
   input  logic [15:0]          i_wrData,
   output logic [15:0]          o_rdData
);

   logic [15:0] r_mem [0:(2**WORD_BITS)-1];

   // Per-lane synchronous write: bit 0 enables the low byte, bit 1 the high byte
   always_ff @(posedge clk) begin
      if (i_byteEn[0]) begin
         r_mem[i_wordAddr][7:0] <= i_wrData[7:0];
      end
      if (i_byteEn[1]) begin
         r_mem[i_wordAddr][15:8] <= i_wrData[15:8];
      end
   end

   assign o_rdData = r_mem[i_wordAddr];

endmodule

// File: rtl/lc3b_memory.sv
// LC-3b main-memory responder on the far side of the MAR/MDR interface.
// A request is latched in the first cycle MIO_EN is seen, R pulses for one
// cycle LATENCY cycles later, reads return the aligned word and writes
// commit at the edge that ends the ready cycle.
// Optional feature macro: LC3B_MEM_ALIGN_CHECK_EN adds the ALIGN_ERR output
// and suppresses word writes to odd addresses.
module lc3b_memory
   import lc3b_pkg::*;
#(
   parameter int    ADDR_BITS = 16,
   parameter int    LATENCY   = DEFAULT_LATENCY,
   parameter string INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MIO_EN,
   input  logic        R_W,
   input  logic        DATA_SIZE,
   input  logic [15:0] MAR,
   input  logic [15:0] MDR_IN,
   output logic [15:0] MDR_OUT,
   output logic        R
`ifdef LC3B_MEM_ALIGN_CHECK_EN
   ,
   output logic        ALIGN_ERR
`endif
);

   localparam int         WORD_BITS = ADDR_BITS - 1;
   localparam logic [3:0] LAST_CNT  = 4'(LATENCY - 1);

   memState_t r_state;
   memState_t w_nextState;
   logic [3:0]  r_cnt;
   logic [3:0]  w_nextCnt;
   logic [15:0] r_mar;
   logic [15:0] r_mdrIn;
   logic        r_rw;
   logic        r_size;
   logic        r_rdy;
   logic [15:0] r_mdrOut;
   logic        w_load;
   logic        w_finish;
   logic        w_commit;
   logic        w_unaligned;
   logic [1:0]  w_byteEn;
   logic [15:0] w_rdData;

   // Word-sized access to an odd byte address
   assign w_unaligned = (r_size == SIZE_WORD) && r_mar[0];

   // Commit only in DONE, and never on an edge where reset is asserted
`ifdef LC3B_MEM_ALIGN_CHECK_EN
   assign w_commit = (r_state == DONE) && (r_rw == RW_WRITE) && rst && !w_unaligned;
`else
   assign w_commit = (r_state == DONE) && (r_rw == RW_WRITE) && rst;
`endif

   // Word stores hit both lanes; byte stores pick the lane from MAR[0]
   assign w_byteEn = !w_commit                ? 2'b00 :
                     (r_size == SIZE_WORD)    ? 2'b11 :
                     r_mar[0]                 ? 2'b10 : 2'b01;

   lc3b_mem_array #(
      .WORD_BITS (WORD_BITS),
      .INIT_FILE (INIT_FILE)
   ) u_array (
      .clk        (clk),
      .i_wordAddr (r_mar[ADDR_BITS-1:1]),
      .i_byteEn   (w_byteEn),
      .i_wrData   (r_mdrIn),
      .o_rdData   (w_rdData)
   );

   // Next-state and counter logic for the IDLE -> BUSY -> DONE handshake
   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_cnt;
      w_load      = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         IDLE: begin
            if (MIO_EN) begin
               w_load      = 1'b1;
               w_nextCnt   = 4'd1;
               w_nextState = BUSY;
            end
         end
         BUSY: begin
            if (!MIO_EN) begin
               w_nextState = IDLE;
               w_nextCnt   = 4'd0;
            end else if (r_cnt == LAST_CNT) begin
               w_nextState = DONE;
               w_finish    = 1'b1;
            end else begin
               w_nextCnt = r_cnt + 4'd1;
            end
         end
         DONE: begin
            w_nextState = IDLE;
            w_nextCnt   = 4'd0;
         end
         default: begin
            w_nextState = IDLE;
            w_nextCnt   = 4'd0;
         end
      endcase
   end

   // State, ready pulse, read data capture and request latching
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_cnt    <= 4'd0;
         r_rdy    <= 1'b0;
         r_mdrOut <= 16'h0000;
      end else begin
         r_state <= w_nextState;
         r_cnt   <= w_nextCnt;
         r_rdy   <= w_finish;
         if (w_load) begin
            r_mar   <= MAR;
            r_mdrIn <= MDR_IN;
            r_rw    <= R_W;
            r_size  <= DATA_SIZE;
         end
         if (w_finish && (r_rw == RW_READ)) begin
            r_mdrOut <= w_rdData;
         end
      end
   end

`ifdef LC3B_MEM_ALIGN_CHECK_EN
   logic r_alignErr;

   // Alignment error flag pulses alongside R for odd word accesses
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_alignErr <= 1'b0;
      end else begin
         r_alignErr <= w_finish && w_unaligned;
      end
   end

   assign ALIGN_ERR = r_alignErr;
`endif

   assign R       = r_rdy;
   assign MDR_OUT = r_mdrOut;

endmodule

// File: tb/tb_lc3b_memory.sv
// Scoreboard bench for lc3b_memory. Unit 0 uses the default latency,
// unit 1 uses LATENCY = 2. Stimulus pushes the expected ready cycle and
// read data; a negedge monitor pops and compares whenever R is high.
// Honors LC3B_MEM_ALIGN_CHECK_EN when the design is built with it.
module tb_lc3b_memory;
   import lc3b_pkg::*;

   localparam int LAT0 = 5;
   localparam int LAT1 = 2;

   typedef struct {
      int          cyc;
      logic [15:0] data;
      bit          chkData;
      logic        align;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        mioEn  [2];
   logic        rw     [2];
   logic        sz     [2];
   logic [15:0] mar    [2];
   logic [15:0] mdrIn  [2];
   logic [15:0] mdrOut [2];
   logic        rdy    [2];
   logic        alignErr [2];

   int   cycleCnt = 0;
   int   checks   = 0;
   int   failures = 0;
   bit   monEn    = 1'b0;
   exp_t sb0[$];
   exp_t sb1[$];

`ifdef LC3B_MEM_ALIGN_CHECK_EN
   localparam logic       ALIGN_ON     = 1'b1;
   localparam logic [15:0] UNALIGNED_RD = 16'h7777;
`else
   localparam logic       ALIGN_ON     = 1'b0;
   localparam logic [15:0] UNALIGNED_RD = 16'h5555;
`endif

   // Free-running clock and cycle counter used to time R pulses
   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   lc3b_memory #(.LATENCY(LAT0)) dut0 (
      .clk       (clk),
      .rst       (rst),
      .MIO_EN    (mioEn[0]),
      .R_W       (rw[0]),
      .DATA_SIZE (sz[0]),
      .MAR       (mar[0]),
      .MDR_IN    (mdrIn[0]),
      .MDR_OUT   (mdrOut[0]),
      .R         (rdy[0])
`ifdef LC3B_MEM_ALIGN_CHECK_EN
      ,
      .ALIGN_ERR (alignErr[0])
`endif
   );

   lc3b_memory #(.LATENCY(LAT1)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .MIO_EN    (mioEn[1]),
      .R_W       (rw[1]),
      .DATA_SIZE (sz[1]),
      .MAR       (mar[1]),
      .MDR_IN    (mdrIn[1]),
      .MDR_OUT   (mdrOut[1]),
      .R         (rdy[1])
`ifdef LC3B_MEM_ALIGN_CHECK_EN
      ,
      .ALIGN_ERR (alignErr[1])
`endif
   );

`ifndef LC3B_MEM_ALIGN_CHECK_EN
   assign alignErr[0] = 1'b0;
   assign alignErr[1] = 1'b0;
`endif

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycleCnt);
      end
   endtask

   task automatic pushExp(input int u, input int cyc, input logic [15:0] data,
                          input bit chkData, input logic align);
      exp_t e;
      e.cyc     = cyc;
      e.data    = data;
      e.chkData = chkData;
      e.align   = align;
      if (u == 0) sb0.push_back(e);
      else        sb1.push_back(e);
   endtask

   // One full access: called at a negedge in IDLE, holds MIO_EN until R,
   // then leaves one idle cycle so the next call starts from IDLE.
   task automatic applyStimulus(input int u, input logic wr, input logic size,
                                input logic [15:0] addr, input logic [15:0] wdata,
                                input logic [15:0] expData, input logic expAlign);
      bit seen;
      int lat;
      lat      = (u == 0) ? LAT0 : LAT1;
      mioEn[u] = 1'b1;
      rw[u]    = wr;
      sz[u]    = size;
      mar[u]   = addr;
      mdrIn[u] = wdata;
      pushExp(u, cycleCnt + lat, expData, (wr == RW_READ), expAlign);
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         if (rdy[u] === 1'b1) seen = 1'b1;
      end
      mioEn[u] = 1'b0;
      if (!seen) begin
         checks++;
         failures++;
         $display("[TB] FAIL timeout unit%0d: R not seen, required within 30 cycles", u);
      end
      @(negedge clk);
   endtask

   // Monitor: every R pulse must match the head of its unit's scoreboard
   always @(negedge clk) begin : monitor
      exp_t e;
      bit   have;
      if (monEn) begin
         for (int u = 0; u < 2; u++) begin
            if (rdy[u] === 1'b1) begin
               have = 1'b0;
               if (u == 0 && sb0.size() > 0) begin
                  e = sb0.pop_front();
                  have = 1'b1;
               end else if (u == 1 && sb1.size() > 0) begin
                  e = sb1.pop_front();
                  have = 1'b1;
               end
               if (!have) begin
                  checks++;
                  failures++;
                  $display("[TB] FAIL unexpected R unit%0d: R=1, expected 0 (cycle %0d)", u, cycleCnt);
               end else begin
                  checkOutput($sformatf("R cycle unit%0d", u), 32'(cycleCnt), 32'(e.cyc));
                  if (e.chkData) begin
                     checkOutput($sformatf("read data unit%0d", u), 32'(mdrOut[u]), 32'(e.data));
                  end
`ifdef LC3B_MEM_ALIGN_CHECK_EN
                  checkOutput($sformatf("ALIGN_ERR unit%0d", u), 32'(alignErr[u]), 32'(e.align));
`endif
               end
            end
         end
      end
   end

   // Hard stop in case something blocks the main sequence
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Directed stimulus sequence
   initial begin
      int pulses;
      rst = 1'b0;
      for (int u = 0; u < 2; u++) begin
         mioEn[u] = 1'b0;
         rw[u]    = RW_READ;
         sz[u]    = SIZE_WORD;
         mar[u]   = 16'h0000;
         mdrIn[u] = 16'h0000;
      end

      repeat (2) begin
         @(negedge clk);
         for (int u = 0; u < 2; u++) begin
            checkOutput($sformatf("reset R unit%0d", u), 32'(rdy[u]), 32'd0);
            checkOutput($sformatf("reset MDR_OUT unit%0d", u), 32'(mdrOut[u]), 32'd0);
         end
      end
      rst   = 1'b1;
      monEn = 1'b1;
      repeat (3) @(negedge clk);

      $display("[TB] word write/read");
      applyStimulus(0, RW_WRITE, SIZE_WORD, 16'h3000, 16'h1234, 16'h0000, 1'b0);
      applyStimulus(0, RW_READ,  SIZE_WORD, 16'h3000, 16'h0000, 16'h1234, 1'b0);

      $display("[TB] byte lanes");
      applyStimulus(0, RW_WRITE, SIZE_BYTE, 16'h3001, 16'hABAB, 16'h0000, 1'b0);
      applyStimulus(0, RW_READ,  SIZE_BYTE, 16'h3001, 16'h0000, 16'hAB34, 1'b0);
      applyStimulus(0, RW_WRITE, SIZE_BYTE, 16'h3000, 16'hCDCD, 16'h0000, 1'b0);
      applyStimulus(0, RW_READ,  SIZE_WORD, 16'h3000, 16'h0000, 16'hABCD, 1'b0);

      $display("[TB] abort by MIO_EN drop in cycle 3");
      mioEn[0] = 1'b1;
      rw[0]    = RW_WRITE;
      sz[0]    = SIZE_WORD;
      mar[0]   = 16'h3000;
      mdrIn[0] = 16'hFFFF;
      repeat (3) @(negedge clk);
      mioEn[0] = 1'b0;
      repeat (8) @(negedge clk);
      applyStimulus(0, RW_READ, SIZE_WORD, 16'h3000, 16'h0000, 16'hABCD, 1'b0);

      $display("[TB] abort by reset in cycle 4");
      mioEn[0] = 1'b1;
      rw[0]    = RW_WRITE;
      sz[0]    = SIZE_WORD;
      mar[0]   = 16'h3000;
      mdrIn[0] = 16'hFFFF;
      repeat (4) @(negedge clk);
      rst      = 1'b0;
      mioEn[0] = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      checkOutput("MDR_OUT after mid reset", 32'(mdrOut[0]), 32'd0);
      repeat (6) @(negedge clk);
      applyStimulus(0, RW_READ, SIZE_WORD, 16'h3000, 16'h0000, 16'hABCD, 1'b0);

      $display("[TB] back-to-back reads");
      applyStimulus(0, RW_WRITE, SIZE_WORD, 16'h3002, 16'h5A5A, 16'h0000, 1'b0);
      mioEn[0] = 1'b1;
      rw[0]    = RW_READ;
      sz[0]    = SIZE_WORD;
      mar[0]   = 16'h3000;
      pushExp(0, cycleCnt + 5,  16'hABCD, 1'b1, 1'b0);
      pushExp(0, cycleCnt + 11, 16'h5A5A, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      mar[0] = 16'h3002;
      pulses = 0;
      for (int i = 0; i < 40 && pulses < 2; i++) begin
         @(negedge clk);
         if (rdy[0] === 1'b1) pulses++;
      end
      mioEn[0] = 1'b0;
      if (pulses < 2) begin
         checks++;
         failures++;
         $display("[TB] FAIL back-to-back pulses: got %0d, expected 2", pulses);
      end
      repeat (3) @(negedge clk);

      $display("[TB] LATENCY=2 unit and unaligned word accesses");
      applyStimulus(1, RW_WRITE, SIZE_WORD, 16'h3000, 16'h7777, 16'h0000, 1'b0);
      applyStimulus(1, RW_READ,  SIZE_WORD, 16'h3000, 16'h0000, 16'h7777, 1'b0);
      applyStimulus(1, RW_WRITE, SIZE_WORD, 16'h3001, 16'h5555, 16'h0000, ALIGN_ON);
      applyStimulus(1, RW_READ,  SIZE_WORD, 16'h3000, 16'h0000, UNALIGNED_RD, 1'b0);
      applyStimulus(1, RW_READ,  SIZE_WORD, 16'h3001, 16'h0000, UNALIGNED_RD, ALIGN_ON);

      repeat (5) @(negedge clk);
      checkOutput("scoreboard drain unit0", 32'(sb0.size()), 32'd0);
      checkOutput("scoreboard drain unit1", 32'(sb1.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
